// File: rtl/hamming_pkg.sv
// Hamming(12,8) constants, payload types and the syndrome/extract helpers.
// The receive decoder and the link's encoder side both use this package.
package hamming_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW_W   = 12;
  localparam int unsigned SYN_W  = 4;

  // Coverage mask of each parity bit (parity positions 1, 2, 4, 8); bit i is position i+1.
  localparam logic [CW_W-1:0] P1_MASK = 12'h555;
  localparam logic [CW_W-1:0] P2_MASK = 12'h666;
  localparam logic [CW_W-1:0] P4_MASK = 12'h878;
  localparam logic [CW_W-1:0] P8_MASK = 12'hF80;

  // Codeword position (1-based) holding each data bit.
  localparam int unsigned D0_POS = 3;
  localparam int unsigned D1_POS = 5;
  localparam int unsigned D2_POS = 6;
  localparam int unsigned D3_POS = 7;
  localparam int unsigned D4_POS = 9;
  localparam int unsigned D5_POS = 10;
  localparam int unsigned D6_POS = 11;
  localparam int unsigned D7_POS = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
  } dec_res_t;

  // XOR of the positions of all set bits, one parity group per syndrome bit.
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    return {^(cw & P8_MASK), ^(cw & P4_MASK), ^(cw & P2_MASK), ^(cw & P1_MASK)};
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[D7_POS-1], cw[D6_POS-1], cw[D5_POS-1], cw[D4_POS-1],
            cw[D3_POS-1], cw[D2_POS-1], cw[D1_POS-1], cw[D0_POS-1]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(12,8) syndrome and single-bit correction.
// A syndrome of 13..15 points outside the codeword, so the data is passed through as received.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic [DATA_W-1:0] data_o
);

  logic [SYN_W-1:0] syn;
  logic [CW_W-1:0]  fixed;

  always_comb begin
    syn   = calc_syndrome(cw_i);
    fixed = cw_i;
    if ((syn != '0) && (syn <= SYN_W'(CW_W))) begin
      fixed = cw_i ^ (CW_W'(1) << (syn - SYN_W'(1)));
    end
    syn_o  = syn;
    data_o = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_stream_decoder.sv
// Serial Hamming(12,8) receiver: deserialize, correct, deliver bytes on valid/ready.
// Optional corrected-error counter on err_cnt when HAMMING_ERR_CNT_EN is defined.
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic              overflow
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int unsigned CNT_BITS       = 4;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CW_W - 1);

  rx_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CW_W-1:0]     sr_q;
  logic [CW_W-1:0]     cw_q;
  logic                decode_pend_q;
  logic                start_c, shift_c, done_c;

  logic [SYN_W-1:0]    syn_c;
  logic [DATA_W-1:0]   dec_data_c;
  dec_res_t            res_q;
  logic                res_valid_q;

  dec_res_t            out_q;
  logic                q_valid_q;
  logic                overflow_q;
  logic                load_c, drop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bit_valid && sof) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_valid && !sof && (cnt_q == LAST_CNT)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sof always restarts a frame, even mid-codeword.
  always_comb begin
    start_c = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_c = bit_valid && sof;
      end
      ST_SHIFT: begin
        start_c = bit_valid && sof;
        shift_c = bit_valid && !sof;
        done_c  = bit_valid && !sof && (cnt_q == LAST_CNT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      sr_q          <= '0;
      cw_q          <= '0;
      decode_pend_q <= 1'b0;
    end else begin
      decode_pend_q <= done_c;
      if (start_c) begin
        sr_q  <= CW_W'(bit_in);
        cnt_q <= CNT_BITS'(1);
      end else if (shift_c) begin
        sr_q[cnt_q] <= bit_in;
        if (done_c) begin
          cnt_q <= '0;
          cw_q  <= {bit_in, sr_q[CW_W-2:0]};
        end else begin
          cnt_q <= cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

  hamming_syndrome u_syndrome (
    .cw_i   (cw_q),
    .syn_o  (syn_c),
    .data_o (dec_data_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= decode_pend_q;
      if (decode_pend_q) begin
        res_q <= '{data:   dec_data_c,
                   corr:   (syn_c != '0) && (syn_c <= SYN_W'(CW_W)),
                   uncorr: (syn_c > SYN_W'(CW_W))};
      end
    end
  end

  // A result arriving while the previous byte is still held is lost.
  assign load_c = res_valid_q && (!q_valid_q || q_ready);
  assign drop_c = res_valid_q && q_valid_q && !q_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      q_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (load_c) begin
        out_q     <= res_q;
        q_valid_q <= 1'b1;
      end else if (q_valid_q && q_ready) begin
        q_valid_q <= 1'b0;
      end
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  assign q          = out_q.data;
  assign err_corr   = out_q.corr;
  assign err_uncorr = out_q.uncorr;
  assign q_valid    = q_valid_q;
  assign overflow   = overflow_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (load_c && res_q.corr && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
